// File: rtl/mem_pkg.sv
// mem_pkg: shared memory defaults and address range helper.
package mem_pkg;

    localparam int DATA_W     = 32;
    localparam int DMEM_DEPTH = 256;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < unsigned'(depth);
    endfunction

endpackage

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory, synchronous write, combinational read.
module data_mem
    import mem_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Data_in,
    input  logic [31:0]      data_add,
    input  logic             en_write,
    output logic [WIDTH-1:0] data_out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    idx;
    logic             in_range;

    assign idx      = data_add[AW-1:0];
    assign in_range = addr_in_range(data_add, DEPTH);

    // An X/Z enable falls through to "no write" in the if condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en_write && in_range) begin
            mem[idx] <= Data_in;
        end
    end

    assign data_out = in_range ? mem[idx] : '0;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: scoreboard bench for data_mem against an array reference model.
module tb_data_mem;
    import mem_pkg::*;

    localparam int D = 256;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Data_in = '0;
    logic [31:0] data_add = '0;
    logic        en_write = 1'b0;
    logic [31:0] data_out;

    logic [31:0] ref_mem [D];
    exp_t        sb [$];
    event        sample_ev;
    int          checks = 0;
    int          errors = 0;

    data_mem dut (
        .clk(clk), .rst_n(rst_n), .Data_in(Data_in),
        .data_add(data_add), .en_write(en_write), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
    endtask

    // Read expectation straight from the reference array: out of range reads zero.
    task automatic check(input string name, input logic [31:0] addr);
        exp_t e;
        data_add = addr;
        #1;
        e.name = name;
        e.addr = addr;
        e.exp  = (addr < D) ? ref_mem[addr] : 32'd0;
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Drive at negedge, model update at posedge, back to negedge.
    task automatic edge_op(input logic [31:0] addr, input logic [31:0] data, input logic en);
        data_add = addr;
        Data_in  = data;
        en_write = en;
        @(posedge clk);
        if (en && rst_n && addr < D) ref_mem[addr] = data;
        @(negedge clk);
        en_write = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.exp) begin
                    errors++;
                    $display("FAIL %s addr=%0d got=%h expected=%h", e.name, e.addr, data_out, e.exp);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] a, d;
        logic        en;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a0", 0);
        check("reset_a2", 2);
        check("reset_a4", 4);
        check("reset_a10", 10);
        check("reset_a255", 255);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_a10", 10);

        edge_op(10, 500, 1'b1);
        check("basic_a10", 10);
        check("basic_a2", 2);
        check("basic_a4", 4);

        for (int i = 0; i < 3; i++) begin
            edge_op(4, 32'hDEADBEEF, 1'b0);
            check("gate_a4", 4);
        end

        edge_op(256, 32'h1234, 1'b1);
        check("oor_a256", 256);
        check("oor_a0", 0);
        check("oor_a10", 10);
        edge_op(32'h8000_000A, 32'h5555, 1'b1);
        check("oor_alias_a10", 10);

        data_add = 10;
        Data_in  = 77;
        en_write = 1'b1;
        check("same_before", 10);
        Data_in  = 77;
        en_write = 1'b1;
        @(posedge clk);
        ref_mem[10] = 77;
        #1;
        check("same_after", 10);
        @(negedge clk);
        en_write = 1'b0;

        edge_op(1, 32'h11, 1'b1);
        edge_op(2, 32'h22, 1'b1);
        edge_op(255, 32'hFF, 1'b1);
        edge_op(2, 32'h33, 1'b1);
        check("b2b_last_wins", 2);
        check("b2b_a255", 255);
        rst_n = 1'b0;
        model_reset();
        check("midrst_a1", 1);
        check("midrst_a2", 2);
        check("midrst_a10", 10);
        edge_op(5, 32'h99, 1'b1);
        check("midrst_write_held", 5);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_write_lost", 5);
        check("midrst_a255", 255);

        for (int i = 0; i < 300; i++) begin
            a  = ($urandom_range(0, 9) == 0) ? (32'(D) + 32'($urandom_range(0, 300))) :
                 32'($urandom_range(0, 31));
            d  = $urandom;
            en = 1'($urandom_range(0, 2) != 0);
            edge_op(a, d, en);
            check("rand_wr_addr", a);
            check("rand_other", 32'($urandom_range(0, 40)));
            if (i == 150) begin
                rst_n = 1'b0;
                model_reset();
                check("rand_reset", a);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
